seq_divider: RTL and testbench

Sequential restoring divider and the inverse datapath of the team's shift-add multiplier. It produces one quotient bit per clock and handles both signed and unsigned operands. It feeds the CPU's DIV instruction: quotient goes to LO and remainder goes to HI. The start/busy/done handshake lets the control unit stall until the result is valid.

---
 rtl/div_pkg.sv | 19 +
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential divider datapath.
// The multiplier can reuse the same state set and handshake.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 32;

  function automatic int div_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, signed or unsigned.
// Quotient feeds LO, remainder feeds HI; done is a one-cycle pulse.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = div_cnt_w(WIDTH);

  state_t state;
  state_t state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] dvd;
  logic             neg_q;
  logic             neg_r;
  logic             zero;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   trial;
  logic             last;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  // R < D always holds, so the shifted value fits in WIDTH+1 bits
  assign sh    = {r, q[WIDTH-1]};
  assign trial = sh - {1'b0, d};
  assign last  = (cnt == CW'(WIDTH - 1));

  assign q_fix = zero  ? '1
               : neg_q ? -q : q;
  assign r_fix = zero  ? dvd
               : neg_r ? -r : r;

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      dvd         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            r           <= '0;
            q           <= a_mag;
            d           <= b_mag;
            dvd         <= dividend;
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            zero        <= (divisor == '0);
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!trial[WIDTH]) begin
            r <= trial[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            r <= sh[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= zero;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider (WIDTH = 32).
// Expected results come from a behavioural divide model.
module tb_seq_divider;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic        s);
    exp_t e;
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    sa  = a;
    sbv = b;
    e.z = 1'b0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (s) begin
      e.q = sa / sbv;
      e.r = sa % sbv;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic        s,
                        input int          glitch_at,
                        input int          reset_at);
    exp_t        e;
    int          busy_n;
    int          lat;
    bit          both;
    bit          got;
    bit          seen;
    logic [31:0] pq;
    logic [31:0] pr;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    pq        = quotient;
    pr        = remainder;
    @(posedge clk);
    sb.push_back(model(a, b, s));
    busy_n = 0;
    lat    = -1;
    both   = 1'b0;
    got    = 1'b0;
    for (int c = 0; c < WIDTH + 8 && !got; c++) begin
      #1;
      if (busy) busy_n++;
      if (busy && done) both = 1'b1;
      if (done) begin
        got = 1'b1;
        lat = c;
      end
      if (c == WIDTH) begin
        chk("hold_q", 64'(quotient), 64'(pq));
        chk("hold_r", 64'(remainder), 64'(pr));
      end
      if (c == reset_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_q", 64'(quotient), 64'd0);
        chk("abort_r", 64'(remainder), 64'd0);
        chk("abort_dbz", 64'(div_by_zero), 64'd0);
        e = sb.pop_back();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (WIDTH + 4) begin
          @(posedge clk);
          #1;
          if (done) seen = 1'b1;
        end
        chk("no_done_after_abort", 64'(seen), 64'd0);
        return;
      end
      if (!got) begin
        @(negedge clk);
        start = (c + 1 == glitch_at);
        if (start) begin
          dividend  = 32'd50;
          divisor   = 32'd5;
          signed_op = 1'b0;
        end else begin
          dividend  = $urandom;
          divisor   = $urandom;
          signed_op = 1'($urandom_range(1));
        end
        @(posedge clk);
      end
    end
    chk("latency", 64'(lat), 64'(WIDTH + 1));
    chk("busy_cycles", 64'(busy_n), 64'(WIDTH));
    chk("busy_done_overlap", 64'(both), 64'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      if (got) begin
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.z));
      end
    end
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, -1, -1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, -1);
    run_op(32'd5, 32'd0, 1'b0, -1, -1);
    run_op(32'd9, 32'd3, 1'b0, -1, -1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, -1, -1);
    run_op(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, -1, -1);
    run_op(32'hFFFF_FFF0, 32'd0, 1'b1, -1, -1);
    run_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, -1, -1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, -1, -1);
    run_op(32'd100, 32'd7, 1'b0, 10, -1);
    run_op(32'd1000, 32'd3, 1'b0, -1, 12);
    run_op(32'd20, 32'd6, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
